seg_display_arbiter: RTL
========================

SEG_DISPLAY_ARBITER -- requirements
Module: seg_display_arbiter

Interface
REQ-001 Parameter NUM_REQ, 4: number of requesters; requester index 0..3.
REQ-002 Parameter DWELL_TICKS, 3: minimum dwell_tick pulses an owner holds the display before a non-urgent handoff.
REQ-003 Port clk  in  1  single system clock; all state on rising edge.
REQ-004 Port reset_n  in  1  reset, asynchronous assert, active-low.
REQ-005 Port scan_tick  in  1  one-cycle pulse; advances the digit scan.
REQ-006 Port dwell_tick  in  1  one-cycle pulse; dwell time unit (metronome).
REQ-007 Port req  in  4  bit i high = requester i wants the display.
REQ-008 Port urgent  in  4  bit i high = requester i request is urgent; ignored unless req[i] is high.
REQ-009 Port pat  in  112  requester i segments at [28i+27:28i]; digit d at [7d+6:7d]; active-low segments.
REQ-010 Port blink  in  1  request blanking blink of the current owner.
REQ-011 Port seg  out  7  active-low segment drive.
REQ-012 Port an  out  4  active-low anode drive.
REQ-013 Port grant  out  4  one-hot owner, or all zero.
REQ-014 Port busy  out  1  high when state is GRANT.

Function
REQ-015 FSM has three states: IDLE (no owner), GRANT (owner displayed), HANDOFF (one blank cycle between owners).
REQ-016 IDLE -> GRANT on the first cycle any req bit is high; the winner is selected that cycle.
REQ-017 Winner selection: the lowest index with req&urgent, if any; otherwise round-robin, searching upward from last_owner+1 with wrap 3->0.
REQ-018 On entry to GRANT, the dwell counter clears to 0, the digit index clears to 0, and last_owner is set to the new owner.
REQ-019 In GRANT, each dwell_tick increments the dwell counter, saturating at DWELL_TICKS.
REQ-020 GRANT -> HANDOFF when the owner's req drops, or when another urgent request is present, or when the counter equals DWELL_TICKS and another req bit is high.
REQ-021 GRANT holds when the owner is the only requester; the counter stays saturated.
REQ-022 HANDOFF lasts exactly one cycle, then goes to GRANT with a freshly selected winner, or to IDLE if req is zero.
REQ-023 A previous owner may win again in HANDOFF only when it is the sole requester.
REQ-024 In GRANT, each scan_tick increments the 2-bit digit index, wrapping 3->0.
REQ-025 In GRANT: an = ~(4'b0001 << idx); seg = the owner's pat digit idx, taken combinationally from the live pat bus (not latched).
REQ-026 In IDLE and HANDOFF: an = 4'b1111 and seg = 7'b1111111.
REQ-027 grant is high only in GRANT, and only for the owner bit.
REQ-028 scan_tick and dwell_tick arriving in the same cycle are both applied; both are ignored outside GRANT.
REQ-029 Latency: req rising to the first anode lit is 1 cycle from IDLE; an owner change always passes through exactly one HANDOFF cycle.

Reset
REQ-030 While reset_n is low: state = IDLE, grant = 0, busy = 0, an = 4'b1111, seg = 7'b1111111, idx = 0, counter = 0, last_owner = 3 (so requester 0 is searched first).
REQ-031 Reset asserted mid-GRANT takes effect asynchronously.
REQ-032 After release, the first edge behaves as IDLE.

Configuration
REQ-033 Macro SEGARB_BLINK_EN.
REQ-034 With SEGARB_BLINK_EN defined: a phase bit toggles on each dwell_tick while in GRANT and clears on entry to GRANT; when blink and phase are both high, an is forced to 4'b1111.
REQ-035 Without SEGARB_BLINK_EN: the blink port is present but ignored, and the phase register is absent.

Structure
REQ-036 ddr_definitions.v holds the state encoding (IDLE=0, GRANT=1, HANDOFF=2), the requester indices (ARROW=0, SCORE=1, COMBO=2, LIVES=3), and the blank constants for seg and an.
REQ-037 One sub-module, segarb_rr_pick, is combinational and maps (req, urgent, last_owner, exclude_owner) to a one-hot winner.

Verification
REQ-038 req=0001 from reset, then 4 scan_ticks -> grant=0001 after 1 cycle; an sequence 1110, 1101, 1011, 0111, then 1110 again.
REQ-039 req=0011 held, owner 0 -> after 3 dwell_ticks: one HANDOFF cycle with an=1111, then grant=0010.
REQ-040 Owner 1 with counter at 1, urgent=1000 and req=1010 -> HANDOFF on the next edge, then grant=1000.
REQ-041 Owner 2 drops req with req=0000 -> HANDOFF, then IDLE with an=1111, grant=0000, busy=0.
REQ-042 reset_n low mid-GRANT -> outputs blank immediately, without waiting for a clock edge; after release, req=0100 -> grant=0100.
REQ-043 SEGARB_BLINK_EN defined, blink=1, owner 0 -> an alternates blank/lit on each dwell_tick; same stimulus without the macro -> never blank.

Source files
------------

// File: rtl/seg_display_arbiter_pkg.sv
// Shared definitions for the segment display arbiter: FSM state encoding,
// requester identities and the blank drive levels for the active-low
// segment and anode outputs.
package seg_display_arbiter_pkg;

  // Geometry of one requester's pattern: four digits of seven segments.
  localparam int DIGITS = 4;
  localparam int SEG_W  = 7;

  // FSM state encoding, kept as plain constants so legacy code can share it.
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_GRANT   = 2'd1;
  localparam logic [1:0] ST_HANDOFF = 2'd2;

  // Who sits on which request line.
  typedef enum logic [1:0] {
    REQ_ARROW = 2'd0,
    REQ_SCORE = 2'd1,
    REQ_COMBO = 2'd2,
    REQ_LIVES = 2'd3
  } req_id_e;

  // Active-low drives: all ones means every segment and every digit is dark.
  localparam logic [SEG_W-1:0]  SEG_BLANK = 7'b111_1111;
  localparam logic [DIGITS-1:0] AN_BLANK  = 4'b1111;

endpackage : seg_display_arbiter_pkg

// File: rtl/segarb_rr_pick.sv
// Combinational winner selection for the segment display arbiter.
// Urgent requests win by lowest index; otherwise a round-robin search starts
// just above the last owner and wraps. When exclude_owner is set the last
// owner is dropped from the candidates unless it is the only requester.
// NUM_REQ must be a power of two so the search pointer wraps by overflow.
module segarb_rr_pick
  import seg_display_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] urgent,
  input  logic [IDX_W-1:0]   last_owner,
  input  logic               exclude_owner,
  output logic [NUM_REQ-1:0] winner
);

  logic [NUM_REQ-1:0] last_oh;
  logic [NUM_REQ-1:0] cand;
  logic [NUM_REQ-1:0] urg;
  logic [IDX_W-1:0]   pos;
  logic               found;

  // Candidate masking, urgent priority scan, then round-robin scan.
  // NOTE: every signal written here gets a default at the top of the block;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    last_oh             = '0;
    last_oh[last_owner] = 1'b1;

    cand = req;
    if (exclude_owner && ((req & ~last_oh) != '0)) begin
      cand = req & ~last_oh;
    end
    urg = cand & urgent;

    winner = '0;
    found  = 1'b0;
    pos    = last_owner;

    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && urg[i]) begin
        winner[i] = 1'b1;
        found     = 1'b1;
      end
    end

    // k = NUM_REQ wraps back onto last_owner itself, the sole-requester case.
    for (int k = 1; k <= NUM_REQ; k++) begin
      pos = last_owner + IDX_W'(k);
      if (!found && cand[pos]) begin
        winner[pos] = 1'b1;
        found       = 1'b1;
      end
    end
  end

endmodule : segarb_rr_pick

// File: rtl/seg_display_arbiter.sv
// Segment display arbiter: several requesters share one multiplexed
// 4-digit, 7-segment display. One owner at a time is scanned out; ownership
// changes go through a single blank HANDOFF cycle. A non-urgent handoff waits
// until the owner has held the display for DWELL_TICKS dwell_tick pulses.
//
// Optional feature macro: SEGARB_BLINK_EN. When defined, a phase bit toggles
// on every dwell_tick in GRANT and, while blink is high, blanks the anodes
// during the odd phase. Without it, blink is accepted but has no effect.
module seg_display_arbiter
  import seg_display_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DWELL_TICKS = 3
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            scan_tick,
  input  logic                            dwell_tick,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ-1:0]              urgent,
  input  logic [NUM_REQ*DIGITS*SEG_W-1:0] pat,
  input  logic                            blink,
  output logic [SEG_W-1:0]                seg,
  output logic [DIGITS-1:0]               an,
  output logic [NUM_REQ-1:0]              grant,
  output logic                            busy
);

  localparam int                IDX_W     = $clog2(NUM_REQ);
  localparam int                CNT_W     = $clog2(DWELL_TICKS + 1);
  localparam logic [CNT_W-1:0]  DWELL_MAX = CNT_W'(DWELL_TICKS);

  logic [1:0]         state_q, state_d;
  logic [IDX_W-1:0]   last_owner_q, last_owner_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         idx_q, idx_d;

  logic [NUM_REQ-1:0] winner;
  logic [IDX_W-1:0]   win_idx;
  logic [NUM_REQ-1:0] owner_oh;
  logic [NUM_REQ-1:0] others;
  logic               in_grant;
  logic               leave_grant;
  logic [DIGITS-1:0]  an_lit;
  logic [SEG_W-1:0]   seg_live;

`ifdef SEGARB_BLINK_EN
  logic phase_q, phase_d;
`else
  wire unused_blink = blink;
`endif

  // Winner selection; the last owner is only held back in HANDOFF.
  segarb_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req           (req),
    .urgent        (urgent),
    .last_owner    (last_owner_q),
    .exclude_owner (state_q == ST_HANDOFF),
    .winner        (winner)
  );

  // Convert the one-hot winner to an index for the owner register.
  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner[i]) win_idx = IDX_W'(i);
    end
  end

  // Owner decode and the conditions that end a GRANT period. In GRANT the
  // owner is always last_owner_q, which is loaded on every entry.
  always_comb begin
    owner_oh               = '0;
    owner_oh[last_owner_q] = 1'b1;
    in_grant               = (state_q == ST_GRANT);
    others                 = req & ~owner_oh;
    leave_grant            = !req[last_owner_q]
                          || ((others & urgent) != '0)
                          || ((cnt_q == DWELL_MAX) && (others != '0));
  end

  // Next-state logic for the FSM, dwell counter, digit index and phase.
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
`ifdef SEGARB_BLINK_EN
    phase_d      = phase_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (req != '0) begin
          state_d      = ST_GRANT;
          last_owner_d = win_idx;
          cnt_d        = '0;
          idx_d        = '0;
`ifdef SEGARB_BLINK_EN
          phase_d      = 1'b0;
`endif
        end
      end

      ST_GRANT: begin
        // Both ticks may land in one cycle; each is applied independently.
        if (dwell_tick) begin
          if (cnt_q != DWELL_MAX) cnt_d = cnt_q + 1'b1;
`ifdef SEGARB_BLINK_EN
          phase_d = ~phase_q;
`endif
        end
        if (scan_tick) idx_d = idx_q + 2'd1;
        if (leave_grant) state_d = ST_HANDOFF;
      end

      ST_HANDOFF: begin
        if (req != '0) begin
          state_d      = ST_GRANT;
          last_owner_d = win_idx;
          cnt_d        = '0;
          idx_d        = '0;
`ifdef SEGARB_BLINK_EN
          phase_d      = 1'b0;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset leaves the search pointer on the top requester so
  // requester 0 is considered first.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      last_owner_q <= IDX_W'(NUM_REQ - 1);
      cnt_q        <= '0;
      idx_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
    end
  end

`ifdef SEGARB_BLINK_EN
  // Blink phase register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) phase_q <= 1'b0;
    else          phase_q <= phase_d;
  end
`endif

  // Display drive: the owner's current digit straight from the live pattern
  // bus; blank in every state other than GRANT. Reset forces IDLE
  // asynchronously, so the outputs blank without waiting for an edge.
  always_comb begin
    an_lit   = ~(4'b0001 << idx_q);
    seg_live = pat[SEG_W * int'({last_owner_q, idx_q}) +: SEG_W];

    grant = '0;
    busy  = in_grant;
    seg   = SEG_BLANK;
    an    = AN_BLANK;

    if (in_grant) begin
      grant = owner_oh;
      seg   = seg_live;
`ifdef SEGARB_BLINK_EN
      an    = (blink && phase_q) ? AN_BLANK : an_lit;
`else
      an    = an_lit;
`endif
    end
  end

endmodule : seg_display_arbiter
